ring_position_display: RTL and testbench



---
 rtl/ring_disp_pkg.sv | 63 ++++++
 rtl/ring_position_display_if.sv | 20 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/ring_position_display.sv | 114 +++++++++++
 tb/tb_ring_position_display.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_disp_pkg.sv
// Shared constants, digit codes and helpers for the ring position display.
package ring_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int unsigned PAT_W      = 8;
  localparam int unsigned IDX_W      = $clog2(PAT_W);
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CODE_W     = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [CODE_W-1:0] CODE_E     = 4'hE;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } pos_t;

  // One-hot check plus index of the (last) set bit.
  function automatic pos_t decode_onehot(input logic [PAT_W-1:0] pat);
    pos_t        res;
    int unsigned ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      if (pat[i]) begin
        ones    = ones + 1;
        res.idx = IDX_W'(i);
      end
    end
    res.ok = (ones == 1);
    return res;
  endfunction

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/ring_position_display_if.sv
// Pattern/strobe input and display/status outputs of ring_position_display.
interface ring_position_display_if;
  logic [7:0] pattern_in;
  logic       step_valid;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic [7:0] rev_count;
  logic       pattern_err;

  modport master (
    output pattern_in, step_valid,
    input  seg_n, dp_n, an_n, rev_count, pattern_err
  );

  modport slave (
    input  pattern_in, step_valid,
    output seg_n, dp_n, an_n, rev_count, pattern_err
  );
endinterface

// File: rtl/seg7_decode.sv
// Digit code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
  import ring_disp_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_code)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      CODE_E:  o_seg_c = SEG_E;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ring_position_display.sv
// Decodes the rotating one-hot position, counts revolutions in BCD and scans a
// 4-digit display. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module ring_position_display
  import ring_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  ring_position_display_if.slave  bus
);

  localparam int unsigned SCAN_DIV = CLK_HZ / (4 * SCAN_HZ);
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [IDX_W-1:0]   r_pos_idx;
  logic               r_pos_ok;
  logic               r_pattern_err;
  logic [7:0]         r_rev_count;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [DIGIT_W-1:0] r_digit_sel;
  logic [SEG_W-1:0]   r_seg_n;
  logic               r_dp_n;
  logic [3:0]         r_an_n;

  pos_t               w_pos;
  logic               w_rev_hit;
  logic [CODE_W-1:0]  w_code;
  logic [SEG_W-1:0]   w_seg;

  assign w_pos     = decode_onehot(bus.pattern_in);
  assign w_rev_hit = bus.step_valid && r_pos_ok && (r_pos_idx == IDX_W'(7)) &&
                     w_pos.ok && (w_pos.idx == IDX_W'(0));

  // Position capture, sticky fault flag and revolution counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos_idx     <= '0;
      r_pos_ok      <= 1'b0;
      r_pattern_err <= 1'b0;
      r_rev_count   <= 8'h00;
    end else if (bus.step_valid) begin
      r_pos_ok <= w_pos.ok;
      if (w_pos.ok) begin
        r_pos_idx <= w_pos.idx;
      end else begin
        r_pattern_err <= 1'b1;
      end
      if (w_rev_hit) begin
        r_rev_count <= bcd_inc(r_rev_count);
      end
    end
  end

  // Digit content for the currently selected anode.
  always_comb begin
    w_code = CODE_BLANK;
    case (r_digit_sel)
      DIGIT_W'(3): begin
`ifdef LEADING_ZERO_BLANK_EN
        w_code = (r_rev_count[7:4] == 4'd0) ? CODE_BLANK : r_rev_count[7:4];
`else
        w_code = r_rev_count[7:4];
`endif
      end
      DIGIT_W'(2): w_code = r_rev_count[3:0];
      DIGIT_W'(1): w_code = CODE_BLANK;
      default: begin
        if (r_pos_ok) begin
          w_code = CODE_W'(r_pos_idx);
        end else if (r_pattern_err) begin
          w_code = CODE_E;
        end else begin
          w_code = CODE_BLANK;
        end
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .i_code  (w_code),
    .o_seg_c (w_seg)
  );

  // Scan timing; segments, anodes and dp latch from the same digit_sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= '0;
      r_seg_n     <= SEG_BLANK;
      r_dp_n      <= 1'b1;
      r_an_n      <= 4'hF;
    end else begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt  <= '0;
        r_digit_sel <= r_digit_sel + DIGIT_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      r_seg_n <= w_seg;
      r_dp_n  <= (r_digit_sel != DIGIT_W'(2));
      r_an_n  <= ~(4'(4'b0001 << r_digit_sel));
    end
  end

  assign bus.seg_n       = r_seg_n;
  assign bus.dp_n        = r_dp_n;
  assign bus.an_n        = r_an_n;
  assign bus.rev_count   = r_rev_count;
  assign bus.pattern_err = r_pattern_err;

endmodule

// File: tb/tb_ring_position_display.sv
// Self-checking bench for ring_position_display (CLK_HZ=1000, SCAN_HZ=50 -> SCAN_DIV=5).
module tb_ring_position_display;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned SCAN_HZ = 50;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ring_position_display_if bus();

  ring_position_display #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rev;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] rev;
    logic       err;
    logic [6:0] d0;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state
  bit m_ok;
  int m_idx;
  int m_rev;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [6:0] d3_exp(input int v);
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 10) return 7'h7F;
`endif
    return seg_lut[v / 10];
  endfunction

  task automatic model_reset();
    m_ok = 0; m_idx = 0; m_rev = 0; m_err = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic [7:0] p);
    bit ok;
    int idx;
    exp_t e;
    ok  = ($countones(p) == 1);
    idx = 0;
    for (int i = 0; i < 8; i++) if (p[i]) idx = i;
    if (ok && m_ok && m_idx == 7 && idx == 0) m_rev = (m_rev + 1) % 100;
    m_ok = ok;
    if (ok) m_idx = idx; else m_err = 1;
    e.rev = to_bcd(m_rev);
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_rev"}, 32'(bus.rev_count), 32'(e.rev));
      chk({name, "_err"}, 32'(bus.pattern_err), 32'(e.err));
    end
  endtask

  // Called at a negedge; one-cycle strobe, checked at N+1.
  task automatic strobe(input logic [7:0] p);
    bus.pattern_in = p;
    bus.step_valid = 1'b1;
    model_step(p);
    @(negedge clk);
    bus.step_valid = 1'b0;
    sb_check("strobe");
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.step_valid = 1'b0;
    bus.pattern_in = 8'h00;
    repeat (n) @(negedge clk);
    chk("rst_an", 32'(bus.an_n), 32'hF);
    chk("rst_seg", 32'(bus.seg_n), 32'h7F);
    chk("rst_dp", 32'(bus.dp_n), 32'd1);
    chk("rst_rev", 32'(bus.rev_count), 32'h00);
    chk("rst_err", 32'(bus.pattern_err), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_an(input logic [3:0] want, input string name);
    int n = 0;
    while (bus.an_n !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.an_n !== want) chk({name, "_timeout"}, 32'(bus.an_n), 32'(want));
  endtask

  task automatic check_slot(input logic [3:0] an, input logic [6:0] seg, input string name);
    @(negedge clk);
    wait_an(an, name);
    chk({name, "_seg"}, 32'(bus.seg_n), 32'(seg));
  endtask

  task automatic wait_change(input logic [3:0] prev, input string name);
    int n = 0;
    while (bus.an_n === prev && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (bus.an_n === prev) chk({name, "_stuck"}, 32'(bus.an_n), 32'(~prev));
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{8'h08, 8'h00, 1'b0, 7'h30};
    vecs[1]  = '{8'h80, 8'h00, 1'b0, 7'h78};
    vecs[2]  = '{8'h01, 8'h01, 1'b0, 7'h40};
    vecs[3]  = '{8'h02, 8'h01, 1'b0, 7'h79};
    vecs[4]  = '{8'h04, 8'h01, 1'b0, 7'h24};
    vecs[5]  = '{8'h08, 8'h01, 1'b0, 7'h30};
    vecs[6]  = '{8'h10, 8'h01, 1'b0, 7'h19};
    vecs[7]  = '{8'h20, 8'h01, 1'b0, 7'h12};
    vecs[8]  = '{8'h40, 8'h01, 1'b0, 7'h02};
    vecs[9]  = '{8'h80, 8'h01, 1'b0, 7'h78};
    vecs[10] = '{8'h00, 8'h01, 1'b1, 7'h06};
    vecs[11] = '{8'h01, 8'h01, 1'b1, 7'h40};

    bus.pattern_in = 8'h00;
    bus.step_valid = 1'b0;
    model_reset();

    // Reset and scan order
    do_reset(3);
    wait_an(4'hE, "scan_d0");
    chk("scan_d0_seg", 32'(bus.seg_n), 32'h7F);
    chk("scan_d0_dp", 32'(bus.dp_n), 32'd1);
    wait_change(4'hE, "scan_d1");
    chk("scan_d1_an", 32'(bus.an_n), 32'hD);
    chk("scan_d1_seg", 32'(bus.seg_n), 32'h7F);
    wait_change(4'hD, "scan_d2");
    chk("scan_d2_an", 32'(bus.an_n), 32'hB);
    chk("scan_d2_seg", 32'(bus.seg_n), 32'h40);
    chk("scan_d2_dp", 32'(bus.dp_n), 32'd0);
    wait_change(4'hB, "scan_d3");
    chk("scan_d3_an", 32'(bus.an_n), 32'h7);
    chk("scan_d3_seg", 32'(bus.seg_n), 32'(d3_exp(0)));
    chk("scan_d3_dp", 32'(bus.dp_n), 32'd1);
    wait_change(4'h7, "scan_wrap");
    chk("scan_wrap_an", 32'(bus.an_n), 32'hE);

    // Table: decode, one revolution, fault entries
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      strobe(vecs[i].pat);
      chk($sformatf("tbl%0d_rev", i), 32'(bus.rev_count), 32'(vecs[i].rev));
      chk($sformatf("tbl%0d_err", i), 32'(bus.pattern_err), 32'(vecs[i].err));
      check_slot(4'hE, vecs[i].d0, $sformatf("tbl%0d_d0", i));
    end

    // Two-bit fault, recovery keeps the sticky flag, reset clears it
    do_reset(2);
    strobe(8'h81);
    check_slot(4'hE, 7'h06, "flt_d0");
    strobe(8'h01);
    check_slot(4'hE, 7'h40, "flt_rec_d0");
    chk("flt_sticky", 32'(bus.pattern_err), 32'd1);
    do_reset(1);

    // 100 revolutions wrap 99 -> 00
    strobe(8'h80);
    for (int r = 0; r < 100; r++) begin
      for (int b = 0; b < 8; b++) strobe(8'(1 << b));
      if (r == 98) chk("wrap_99", 32'(bus.rev_count), 32'h99);
    end
    chk("wrap_00", 32'(bus.rev_count), 32'h00);

    // Reset coinciding with a 7->0 step
    do_reset(1);
    strobe(8'h80);
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 8; b++) strobe(8'(1 << b));
    chk("mid_rev05", 32'(bus.rev_count), 32'h05);
    bus.pattern_in = 8'h01;
    bus.step_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rev", 32'(bus.rev_count), 32'h00);
    chk("mid_rst_an", 32'(bus.an_n), 32'hF);
    bus.step_valid = 1'b0;
    reset = 1'b0;
    model_reset();

    // Held strobe counts the 7->0 edge once
    strobe(8'h80);
    bus.pattern_in = 8'h01;
    bus.step_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      model_step(8'h01);
      @(negedge clk);
      sb_check($sformatf("held%0d", c));
    end
    bus.step_valid = 1'b0;
    chk("held_rev", 32'(bus.rev_count), 32'h01);
    check_slot(4'h7, d3_exp(m_rev), "held_d3");
    check_slot(4'hB, 7'h79, "held_d2");
    chk("held_d2_dp", 32'(bus.dp_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
